// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EXE->MEM payload, data-SRAM response, flush and MEM->WB/decode signals
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_mem_req;
    logic [2:0]  es_ld_op;
    logic [1:0]  es_addr_lo;
    logic [31:0] es_result;
    logic        es_excp;
    logic [15:0] es_excp_num;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        excp_flush;
    logic        ertn_flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic [31:0] ms_final_result;
    logic        ms_excp;
    logic [15:0] ms_excp_num;
    logic        ms_ex;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;
    logic        ms_fwd_busy;

    modport slave (
        input  es_to_ms_valid, es_pc, es_dest, es_gr_we, es_mem_req, es_ld_op,
               es_addr_lo, es_result, es_excp, es_excp_num,
               data_sram_data_ok, data_sram_rdata, excp_flush, ertn_flush, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_gr_we, ms_final_result,
               ms_excp, ms_excp_num, ms_ex, ms_fwd_valid, ms_fwd_dest, ms_fwd_data,
               ms_fwd_busy
    );

    modport master (
        output es_to_ms_valid, es_pc, es_dest, es_gr_we, es_mem_req, es_ld_op,
               es_addr_lo, es_result, es_excp, es_excp_num,
               data_sram_data_ok, data_sram_rdata, excp_flush, ertn_flush, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_gr_we, ms_final_result,
               ms_excp, ms_excp_num, ms_ex, ms_fwd_valid, ms_fwd_dest, ms_fwd_data,
               ms_fwd_busy
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: waits for data-SRAM response, buffers, extends loads
module mem_stage #(
    parameter int DISCARD_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  bus
);
    typedef enum logic [1:0] {S_EMPTY, S_PASS, S_WAIT, S_HOLD} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DISCARD_W-1:0] r_discard;
    logic [DISCARD_W-1:0] w_discard_nxt;

    logic [31:0] r_pc;
    logic [4:0]  r_dest;
    logic        r_gr_we;
    logic [2:0]  r_ld_op;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_result;
    logic        r_excp;
    logic [15:0] r_excp_num;
    logic [31:0] r_rdata_buf;

    logic        w_flush;
    logic        w_valid;
    logic        w_ready_go;
    logic        w_allowin;
    logic        w_latch;
    logic        w_deliver;
    logic        w_capture;
    logic        w_disc_inc;
    logic        w_disc_dec;
    logic [31:0] w_ld_src;
    logic [31:0] w_shifted;
    logic [31:0] w_final;

    assign w_flush   = bus.excp_flush | bus.ertn_flush;
    assign w_valid   = (r_state != S_EMPTY);
    assign w_deliver = (r_state == S_WAIT) && bus.data_sram_data_ok && (r_discard == '0);

    always_comb begin
        w_ready_go = 1'b0;
        case (r_state)
            S_PASS, S_HOLD: w_ready_go = 1'b1;
            S_WAIT:         w_ready_go = w_deliver;
            default:        w_ready_go = 1'b0;
        endcase
    end

    assign w_allowin = !w_valid || (w_ready_go && bus.ws_allowin) || w_flush;
    assign w_latch   = bus.es_to_ms_valid && w_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_EMPTY;
            r_discard <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    // A new payload wins over flush/handoff; a response that writeback cannot take yet is parked.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        if (w_latch) begin
            w_state_nxt = (bus.es_mem_req && !bus.es_excp) ? S_WAIT : S_PASS;
        end else if (w_flush || (w_ready_go && bus.ws_allowin)) begin
            w_state_nxt = S_EMPTY;
        end else if (w_deliver) begin
            w_state_nxt = S_HOLD;
            w_capture   = 1'b1;
        end
    end

    // Responses owed to flushed accesses are counted so they never reach a younger load.
    assign w_disc_inc = w_flush && (r_state == S_WAIT) && !w_deliver;
    assign w_disc_dec = bus.data_sram_data_ok && (r_discard != '0);

    always_comb begin
        w_discard_nxt = r_discard;
        if (w_disc_inc && !w_disc_dec) begin
            if (!(&r_discard))
                w_discard_nxt = r_discard + 1'b1;
        end else if (w_disc_dec && !w_disc_inc) begin
            w_discard_nxt = r_discard - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc        <= '0;
            r_dest      <= '0;
            r_gr_we     <= 1'b0;
            r_ld_op     <= '0;
            r_addr_lo   <= '0;
            r_result    <= '0;
            r_excp      <= 1'b0;
            r_excp_num  <= '0;
            r_rdata_buf <= '0;
        end else begin
            if (w_latch) begin
                r_pc       <= bus.es_pc;
                r_dest     <= bus.es_dest;
                r_gr_we    <= bus.es_gr_we;
                r_ld_op    <= bus.es_ld_op;
                r_addr_lo  <= bus.es_addr_lo;
                r_result   <= bus.es_result;
                r_excp     <= bus.es_excp;
                r_excp_num <= bus.es_excp_num;
            end
            if (w_capture)
                r_rdata_buf <= bus.data_sram_rdata;
        end
    end

    assign w_ld_src  = (r_state == S_HOLD) ? r_rdata_buf : bus.data_sram_rdata;
    assign w_shifted = w_ld_src >> {r_addr_lo, 3'b000};

    always_comb begin
        w_final = r_result;
        case (r_ld_op)
            3'b001:  w_final = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b101:  w_final = {24'h0, w_shifted[7:0]};
            3'b010:  w_final = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b110:  w_final = {16'h0, w_shifted[15:0]};
            3'b011:  w_final = w_ld_src;
            default: w_final = r_result;
        endcase
    end

    assign bus.ms_allowin      = w_allowin;
    assign bus.ms_to_ws_valid  = w_valid && w_ready_go && !w_flush;
    assign bus.ms_pc           = r_pc;
    assign bus.ms_dest         = r_dest;
    assign bus.ms_gr_we        = r_gr_we;
    assign bus.ms_final_result = w_final;
    assign bus.ms_excp         = r_excp;
    assign bus.ms_excp_num     = r_excp_num;
    assign bus.ms_ex           = w_valid && r_excp;
    assign bus.ms_fwd_valid    = w_valid && r_gr_we && (r_dest != 5'd0);
    assign bus.ms_fwd_dest     = r_dest;
    assign bus.ms_fwd_data     = w_final;
    assign bus.ms_fwd_busy     = w_valid && (r_state == S_WAIT) && (r_ld_op != 3'b000);
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed bench for mem_stage with a transaction-level reference model
module tb_mem_stage;
    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    mem_stage_if bus ();

    mem_stage #(.DISCARD_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction currently held, whether its response is parked, responses owed.
    logic        m_valid;
    logic        m_need;
    logic        m_got;
    logic [31:0] m_buf;
    int          m_owed;
    logic [31:0] m_pc;
    logic [4:0]  m_dest;
    logic        m_gr_we;
    logic [2:0]  m_ld_op;
    logic [1:0]  m_lo;
    logic [31:0] m_result;
    logic        m_excp;
    logic [15:0] m_excp_num;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] lo,
                                            input logic [31:0] data);
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] h;
        s = data >> (8 * lo);
        b = s & 32'h0000_00FF;
        h = s & 32'h0000_FFFF;
        case (op)
            3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd5:    return b;
            3'd2:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd6:    return h;
            default: return data;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_need = 0; m_got = 0; m_buf = 0; m_owed = 0;
        m_pc = 0; m_dest = 0; m_gr_we = 0; m_ld_op = 0; m_lo = 0;
        m_result = 0; m_excp = 0; m_excp_num = 0;
    endtask

    always @(negedge clk) begin
        logic        flush, waiting, ready, allow, deliver, drop, inc, is_load;
        logic [31:0] exp_res;
        if (!resetn) model_reset();
        flush   = bus.excp_flush | bus.ertn_flush;
        waiting = m_valid && m_need && !m_got;
        ready   = m_valid && (!waiting || (bus.data_sram_data_ok && m_owed == 0));
        allow   = !m_valid || (ready && bus.ws_allowin) || flush;
        is_load = (m_ld_op == 3'd1) || (m_ld_op == 3'd2) || (m_ld_op == 3'd3) ||
                  (m_ld_op == 3'd5) || (m_ld_op == 3'd6);
        exp_res = is_load ? extract(m_ld_op, m_lo, m_got ? m_buf : bus.data_sram_rdata) : m_result;

        chk("allowin",   32'(bus.ms_allowin),     32'(allow));
        chk("to_ws",     32'(bus.ms_to_ws_valid), 32'(ready && !flush));
        chk("pc",        bus.ms_pc,               m_pc);
        chk("dest",      32'(bus.ms_dest),        32'(m_dest));
        chk("gr_we",     32'(bus.ms_gr_we),       32'(m_gr_we));
        chk("result",    bus.ms_final_result,     exp_res);
        chk("excp",      32'(bus.ms_excp),        32'(m_excp));
        chk("excp_num",  32'(bus.ms_excp_num),    32'(m_excp_num));
        chk("ex",        32'(bus.ms_ex),          32'(m_valid && m_excp));
        chk("fwd_valid", 32'(bus.ms_fwd_valid),   32'(m_valid && m_gr_we && m_dest != 0));
        chk("fwd_dest",  32'(bus.ms_fwd_dest),    32'(m_dest));
        chk("fwd_data",  bus.ms_fwd_data,         exp_res);
        chk("fwd_busy",  32'(bus.ms_fwd_busy),    32'(waiting && m_ld_op != 0));

        if (resetn) begin
            deliver = waiting && bus.data_sram_data_ok && m_owed == 0;
            drop    = bus.data_sram_data_ok && m_owed > 0;
            inc     = flush && waiting && !deliver;
            if (inc && !drop) begin
                if (m_owed < 3) m_owed++;
            end else if (drop && !inc) begin
                m_owed--;
            end
            if (bus.es_to_ms_valid && allow) begin
                m_valid = 1; m_got = 0;
                m_need = bus.es_mem_req && !bus.es_excp;
                m_pc = bus.es_pc; m_dest = bus.es_dest; m_gr_we = bus.es_gr_we;
                m_ld_op = bus.es_ld_op; m_lo = bus.es_addr_lo; m_result = bus.es_result;
                m_excp = bus.es_excp; m_excp_num = bus.es_excp_num;
            end else if (flush || (ready && bus.ws_allowin)) begin
                m_valid = 0; m_got = 0;
            end else if (deliver) begin
                m_got = 1; m_buf = bus.data_sram_rdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] dest, input logic req,
                        input logic [2:0] op, input logic [1:0] lo, input logic [31:0] res,
                        input logic excp, input logic [15:0] num);
        bus.es_to_ms_valid = 1'b1;
        bus.es_pc = pc; bus.es_dest = dest; bus.es_gr_we = 1'b1;
        bus.es_mem_req = req; bus.es_ld_op = op; bus.es_addr_lo = lo;
        bus.es_result = res; bus.es_excp = excp; bus.es_excp_num = num;
        tick();
        bus.es_to_ms_valid = 1'b0;
    endtask

    logic [2:0] ops [5];

    initial begin
        checks = 0; failures = 0;
        model_reset();
        ops[0] = 3'd1; ops[1] = 3'd2; ops[2] = 3'd3; ops[3] = 3'd5; ops[4] = 3'd6;
        resetn = 1'b0;
        bus.es_to_ms_valid = 0; bus.es_pc = 0; bus.es_dest = 0; bus.es_gr_we = 0;
        bus.es_mem_req = 0; bus.es_ld_op = 0; bus.es_addr_lo = 0; bus.es_result = 0;
        bus.es_excp = 0; bus.es_excp_num = 0; bus.data_sram_data_ok = 0;
        bus.data_sram_rdata = 32'h0BAD_F00D; bus.excp_flush = 0; bus.ertn_flush = 0;
        bus.ws_allowin = 1;
        tick(); tick();
        #1;
        chk("rst_allowin", 32'(bus.ms_allowin), 32'd1);
        chk("rst_to_ws",   32'(bus.ms_to_ws_valid), 32'd0);
        chk("rst_result",  bus.ms_final_result, 32'h0);
        resetn = 1'b1;

        // ALU pass-through
        send(32'h100, 5'd7, 1'b0, 3'd0, 2'd0, 32'h1234_5678, 1'b0, 16'h0);
        #1;
        chk("alu_to_ws",  32'(bus.ms_to_ws_valid), 32'd1);
        chk("alu_result", bus.ms_final_result, 32'h1234_5678);
        tick();

        // ld.b / ld.bu with bypass on the second cycle
        for (int k = 0; k < 2; k++) begin
            send(32'h110 + 32'(k), 5'd8, 1'b1, (k == 0) ? 3'd1 : 3'd5, 2'd2, 32'h0, 1'b0, 16'h0);
            #1;
            chk("ldb_busy", 32'(bus.ms_fwd_busy), 32'd1);
            chk("ldb_wait", 32'(bus.ms_to_ws_valid), 32'd0);
            tick();
            bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h0080_0000;
            #1;
            chk("ldb_to_ws", 32'(bus.ms_to_ws_valid), 32'd1);
            chk("ldb_result", bus.ms_final_result, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            tick();
            bus.data_sram_data_ok = 0;
        end

        // ld.h parked in HOLD while writeback stalls
        send(32'h120, 5'd9, 1'b1, 3'd2, 2'd2, 32'h0, 1'b0, 16'h0);
        bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h8001_0000; bus.ws_allowin = 0;
        tick();
        bus.data_sram_data_ok = 0; bus.data_sram_rdata = 32'h5A5A_5A5A;
        #1;
        chk("hold_result0", bus.ms_final_result, 32'hFFFF_8001);
        tick();
        bus.data_sram_rdata = 32'h1357_2468;
        #1;
        chk("hold_result1", bus.ms_final_result, 32'hFFFF_8001);
        chk("hold_to_ws", 32'(bus.ms_to_ws_valid), 32'd1);
        tick();
        bus.ws_allowin = 1;
        #1;
        chk("hold_result2", bus.ms_final_result, 32'hFFFF_8001);
        tick();
        #1;
        chk("hold_gone", 32'(bus.ms_to_ws_valid), 32'd0);

        // flush in WAIT, stale response dropped
        send(32'h130, 5'd10, 1'b1, 3'd3, 2'd0, 32'h0, 1'b0, 16'h0);
        bus.excp_flush = 1;
        #1;
        chk("flush_allowin", 32'(bus.ms_allowin), 32'd1);
        tick();
        bus.excp_flush = 0;
        #1;
        chk("flush_fwd", 32'(bus.ms_fwd_valid), 32'd0);
        send(32'h134, 5'd11, 1'b1, 3'd3, 2'd0, 32'h0, 1'b0, 16'h0);
        bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("stale_drop", 32'(bus.ms_to_ws_valid), 32'd0);
        tick();
        bus.data_sram_rdata = 32'h0000_0042;
        #1;
        chk("fresh_to_ws", 32'(bus.ms_to_ws_valid), 32'd1);
        chk("fresh_result", bus.ms_final_result, 32'h0000_0042);
        tick();
        bus.data_sram_data_ok = 0;

        // exception without access
        send(32'h140, 5'd3, 1'b0, 3'd0, 2'd0, 32'h55, 1'b1, 16'h0040);
        #1;
        chk("exc_to_ws", 32'(bus.ms_to_ws_valid), 32'd1);
        chk("exc_ex", 32'(bus.ms_ex), 32'd1);
        chk("exc_num", 32'(bus.ms_excp_num), 32'h40);
        tick();

        // discard counter saturation: four flushed loads, three owed responses
        for (int i = 0; i < 4; i++) begin
            send(32'h150 + 32'(i), 5'd12, 1'b1, 3'd3, 2'd0, 32'h0, 1'b0, 16'h0);
            bus.ertn_flush = 1;
            tick();
            bus.ertn_flush = 0;
        end
        send(32'h160, 5'd12, 1'b1, 3'd3, 2'd0, 32'h0, 1'b0, 16'h0);
        bus.data_sram_data_ok = 1;
        for (int i = 0; i < 3; i++) begin
            bus.data_sram_rdata = 32'h100 + 32'(i);
            #1;
            chk("sat_drop", 32'(bus.ms_to_ws_valid), 32'd0);
            tick();
        end
        bus.data_sram_rdata = 32'h0000_00A5;
        #1;
        chk("sat_deliver", bus.ms_final_result, 32'h0000_00A5);
        tick();
        bus.data_sram_data_ok = 0;

        // every load op at every byte offset, alternating bypass and HOLD
        for (int o = 0; o < 5; o++) begin
            for (int lo = 0; lo < 4; lo++) begin
                send(32'h200 + 32'(o * 4 + lo), 5'(lo), 1'b1, ops[o], 2'(lo), 32'h0, 1'b0, 16'h0);
                bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h8F7E_6DDC;
                bus.ws_allowin = 1'(lo & 1);
                tick();
                bus.data_sram_data_ok = 0; bus.data_sram_rdata = 32'hFFFF_FFFF;
                bus.ws_allowin = 1;
                tick();
            end
        end

        // asynchronous reset during WAIT
        send(32'h300, 5'd13, 1'b1, 3'd3, 2'd0, 32'h0, 1'b0, 16'h0);
        #1;
        chk("prerst_busy", 32'(bus.ms_fwd_busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("arst_pc", bus.ms_pc, 32'h0);
        chk("arst_busy", 32'(bus.ms_fwd_busy), 32'd0);
        chk("arst_dest", 32'(bus.ms_dest), 32'd0);
        tick(); tick();
        resetn = 1'b1;
        bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h77;
        #1;
        chk("post_rst_to_ws", 32'(bus.ms_to_ws_valid), 32'd0);
        chk("post_rst_result", bus.ms_final_result, 32'h0);
        tick();
        bus.data_sram_data_ok = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
